// File: rtl/sdram_bus_pkg.sv
// Shared constants and types for the SDRAMBus client arbiter.
package sdram_bus_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner search over a doubled request vector, starting at rr_ptr
// (or at 0 in fixed-priority mode) and wrapping modulo N.
module rr_picker
  import sdram_bus_pkg::*;
#(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic          mode,
  output logic [IW-1:0] winner,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [IW-1:0]  start;

  always_comb begin
    dbl    = {req, req};
    start  = (mode == 1'(PRIO_FIXED)) ? '0 : rr_ptr;
    winner = '0;
    valid  = 1'b0;
    // Scan downwards so the lowest position inside the window is the last write.
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(start)) && (j < int'(start) + N)) begin
        winner = (j >= N) ? IW'(j - N) : IW'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// N-client arbiter in front of SDRAMBus: grants one client, latches its command
// until sdram_finished, and routes the completion pulse back to that client.
module sdram_arbiter
  import sdram_bus_pkg::*;
#(
  parameter  int NUM_CLIENTS = 5,
  parameter  int ADDR_W      = SDRAM_ADDR_W,
  parameter  int DATA_W      = SDRAM_DATA_W,
  parameter  int PRIO_MODE   = PRIO_RR,
  localparam int IW          = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CLIENTS-1:0]        client_read,
  input  logic [NUM_CLIENTS-1:0]        client_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_writedata,
  output logic [DATA_W-1:0]             client_readdata,
  output logic [NUM_CLIENTS-1:0]        client_finished,
  output logic                          sdram_read,
  output logic                          sdram_write,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic [DATA_W-1:0]             sdram_writedata,
  input  logic [DATA_W-1:0]             sdram_readdata,
  input  logic                          sdram_finished,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          cmd_conflict
);

  // Handshake: a client holds read/write until it sees its client_finished bit;
  // the SDRAMBus side sees a stable command from grant until sdram_finished.
  localparam logic [IW-1:0] LAST_ID    = IW'(NUM_CLIENTS - 1);
  localparam logic          MODE_FIXED = (PRIO_MODE == PRIO_RR) ? 1'b0 : 1'b1;

  arb_state_t        state_q, state_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              conflict_q, conflict_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_CLIENTS-1:0] req;
  logic [IW-1:0]          winner;
  logic                   win_valid;

  assign req = client_read | client_write;

  rr_picker #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .mode   (MODE_FIXED),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    write_d    = write_q;
    conflict_d = conflict_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d    = ARB_BUSY;
          // Write wins when a client raises both; the conflict is remembered.
          write_d    = client_write[winner];
          read_d     = client_read[winner] & ~client_write[winner];
          conflict_d = conflict_q | (client_read[winner] & client_write[winner]);
          addr_d     = client_addr[winner*ADDR_W +: ADDR_W];
          wdata_d    = client_writedata[winner*DATA_W +: DATA_W];
          grant_d    = winner;
          rr_ptr_d   = (winner == LAST_ID) ? '0 : winner + 1'b1;
        end
      end
      ARB_BUSY: begin
        if (sdram_finished) begin
          state_d = ARB_IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ARB_IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      conflict_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      write_q    <= write_d;
      conflict_q <= conflict_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    client_finished = '0;
    if ((state_q == ARB_BUSY) && sdram_finished) client_finished[grant_q] = 1'b1;
  end

  assign client_readdata = sdram_readdata;
  assign sdram_read      = read_q;
  assign sdram_write     = write_q;
  assign sdram_addr      = addr_q;
  assign sdram_writedata = wdata_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q == ARB_BUSY);
  assign cmd_conflict    = conflict_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: instance 0 round-robin, instance 1 fixed priority,
// directed vectors plus randomized traffic against a transaction-level model.
module tb_sdram_arbiter;

  localparam int N  = 5;
  localparam int A  = 23;
  localparam int D  = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   c_rd [2];
  logic [N-1:0]   c_wr [2];
  logic [N*A-1:0] c_addr [2];
  logic [N*D-1:0] c_wd [2];
  logic [D-1:0]   s_rdata [2];
  logic           s_fin [2];

  logic [D-1:0]  o_rdata [2];
  logic [N-1:0]  o_fin [2];
  logic          o_rd [2];
  logic          o_wr [2];
  logic [A-1:0]  o_addr [2];
  logic [D-1:0]  o_wd [2];
  logic [IW-1:0] o_gid [2];
  logic          o_busy [2];
  logic          o_conf [2];

  sdram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(A), .DATA_W(D), .PRIO_MODE(0)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .client_read(c_rd[0]), .client_write(c_wr[0]),
    .client_addr(c_addr[0]), .client_writedata(c_wd[0]),
    .client_readdata(o_rdata[0]), .client_finished(o_fin[0]),
    .sdram_read(o_rd[0]), .sdram_write(o_wr[0]),
    .sdram_addr(o_addr[0]), .sdram_writedata(o_wd[0]),
    .sdram_readdata(s_rdata[0]), .sdram_finished(s_fin[0]),
    .grant_id(o_gid[0]), .busy(o_busy[0]), .cmd_conflict(o_conf[0])
  );

  sdram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(A), .DATA_W(D), .PRIO_MODE(1)) dut_fx (
    .i_clk(clk), .i_rst(rst),
    .client_read(c_rd[1]), .client_write(c_wr[1]),
    .client_addr(c_addr[1]), .client_writedata(c_wd[1]),
    .client_readdata(o_rdata[1]), .client_finished(o_fin[1]),
    .sdram_read(o_rd[1]), .sdram_write(o_wr[1]),
    .sdram_addr(o_addr[1]), .sdram_writedata(o_wd[1]),
    .sdram_readdata(s_rdata[1]), .sdram_finished(s_fin[1]),
    .grant_id(o_gid[1]), .busy(o_busy[1]), .cmd_conflict(o_conf[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction per instance.
  logic          m_busy [2];
  logic [IW-1:0] m_grant [2];
  int            m_ptr [2];
  logic          m_rd [2];
  logic          m_wr [2];
  logic [A-1:0]  m_addr [2];
  logic [D-1:0]  m_wd [2];
  logic          m_conf [2];
  logic [N-1:0]  fin_seen [2];

  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] got_q[$];

  typedef struct {
    int           client;
    logic         rd;
    logic         wr;
    logic [A-1:0] addr;
    logic [D-1:0] wd;
    logic [D-1:0] rdata;
    logic         exp_rd;
    logic         exp_wr;
    logic [N-1:0] exp_fin;
    logic         exp_conf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int start);
    int w;
    w = -1;
    for (int k = N-1; k >= 0; k--) if (req[(start + k) % N]) w = (start + k) % N;
    return w;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 1'b0; m_grant[m] = '0; m_ptr[m] = 0;
      m_rd[m] = 1'b0; m_wr[m] = 1'b0; m_addr[m] = '0; m_wd[m] = '0;
      m_conf[m] = 1'b0; fin_seen[m] = '0;
    end
  endtask

  task automatic model_update(input int m);
    int g;
    if (rst) begin
      model_reset();
    end else if (!m_busy[m]) begin
      g = pick(c_rd[m] | c_wr[m], (m == 1) ? 0 : m_ptr[m]);
      if (g >= 0) begin
        m_busy[m]  = 1'b1;
        m_grant[m] = IW'(g);
        m_wr[m]    = c_wr[m][g];
        m_rd[m]    = c_rd[m][g] & ~c_wr[m][g];
        if (c_rd[m][g] && c_wr[m][g]) m_conf[m] = 1'b1;
        m_addr[m]  = c_addr[m][g*A +: A];
        m_wd[m]    = c_wd[m][g*D +: D];
        m_ptr[m]   = (g + 1) % N;
      end
    end else if (s_fin[m]) begin
      m_busy[m] = 1'b0;
      m_rd[m]   = 1'b0;
      m_wr[m]   = 1'b0;
    end
  endtask

  // One clock for instance m: check combinational outputs, advance model, check registers.
  task automatic step(input int m);
    logic [N-1:0] ef;
    logic         was_busy;
    #1;
    ef = '0;
    if (m_busy[m] && s_fin[m] && !rst) ef[m_grant[m]] = 1'b1;
    fin_seen[m] = ef;
    chk("client_finished", o_fin[m], ef);
    chk("client_readdata", o_rdata[m], s_rdata[m]);
    was_busy = o_busy[m];
    model_update(m);
    @(posedge clk);
    #1;
    chk("sdram_read", o_rd[m], m_rd[m]);
    chk("sdram_write", o_wr[m], m_wr[m]);
    chk("sdram_addr", o_addr[m], m_addr[m]);
    chk("sdram_writedata", o_wd[m], m_wd[m]);
    chk("grant_id", o_gid[m], m_grant[m]);
    chk("busy", o_busy[m], m_busy[m]);
    chk("cmd_conflict", o_conf[m], m_conf[m]);
    if (!was_busy && o_busy[m]) got_q.push_back(o_gid[m]);
  endtask

  task automatic do_reset();
    for (int m = 0; m < 2; m++) begin
      c_rd[m] = '0; c_wr[m] = '0; c_addr[m] = '0; c_wd[m] = '0;
      s_fin[m] = 1'b0; s_rdata[m] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    got_q.delete();
    for (int m = 0; m < 2; m++) begin
      chk("reset_busy", o_busy[m], 1'b0);
      chk("reset_read", o_rd[m], 1'b0);
      chk("reset_write", o_wr[m], 1'b0);
      chk("reset_grant", o_gid[m], '0);
      chk("reset_conflict", o_conf[m], 1'b0);
      chk("reset_addr", o_addr[m], '0);
    end
  endtask

  task automatic compare_order(input string name);
    logic [IW-1:0] e;
    logic [IW-1:0] g;
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk(name, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic random_phase(input int m, input int cycles);
    int           wait_cnt [N];
    int           max_wait;
    int           n_grants;
    int           kind;
    logic [N-1:0] req;
    logic         was_busy;
    max_wait = 0;
    n_grants = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((c_rd[m][i] | c_wr[m][i]) && fin_seen[m][i]) begin
          c_rd[m][i] = 1'b0;
          c_wr[m][i] = 1'b0;
        end else if (!(c_rd[m][i] | c_wr[m][i]) && $urandom_range(0, 3) == 0) begin
          kind = $urandom_range(0, 9);
          c_rd[m][i] = (kind < 5);
          c_wr[m][i] = (kind >= 5) || (kind == 0);
          c_addr[m][i*A +: A] = A'($urandom);
          c_wd[m][i*D +: D] = $urandom;
        end else if ((c_rd[m][i] | c_wr[m][i]) && $urandom_range(0, 4) == 0) begin
          c_addr[m][i*A +: A] = A'($urandom);
        end
      end
      s_fin[m]   = m_busy[m] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      s_rdata[m] = $urandom;
      req        = c_rd[m] | c_wr[m];
      was_busy   = m_busy[m];
      step(m);
      if (!was_busy && m_busy[m]) begin
        n_grants++;
        for (int i = 0; i < N; i++) begin
          if (i == int'(m_grant[m])) wait_cnt[i] = 0;
          else if (req[i]) wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
      for (int i = 0; i < N; i++) if (!(c_rd[m][i] | c_wr[m][i])) wait_cnt[i] = 0;
    end
    chk("random_grants_seen", 64'(n_grants > 10), 64'(1));
    if (m == 0) chk("rr_max_wait_bound", 64'(max_wait <= N - 1), 64'(1));
  endtask

  initial begin
    vecs[0] = '{2, 1'b1, 1'b0, 23'h001234, 32'h0000_0000, 32'hDEADBEEF, 1'b1, 1'b0, 5'b00100, 1'b0};
    vecs[1] = '{3, 1'b0, 1'b1, 23'h7FFFFF, 32'h0000_00A5, 32'h1111_2222, 1'b0, 1'b1, 5'b01000, 1'b0};
    vecs[2] = '{1, 1'b1, 1'b1, 23'h2AAAAA, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b1, 5'b00010, 1'b1};
    vecs[3] = '{4, 1'b1, 1'b0, 23'h155555, 32'h0000_0000, 32'h0BAD_C0DE, 1'b1, 1'b0, 5'b10000, 1'b1};

    rst = 1'b1;
    model_reset();
    do_reset();

    // Single-client transactions; address is changed mid-BUSY to prove latching.
    for (int v = 0; v < 4; v++) begin
      c_rd[0][vecs[v].client] = vecs[v].rd;
      c_wr[0][vecs[v].client] = vecs[v].wr;
      c_addr[0][vecs[v].client*A +: A] = vecs[v].addr;
      c_wd[0][vecs[v].client*D +: D] = vecs[v].wd;
      step(0);
      chk("vec_read", o_rd[0], vecs[v].exp_rd);
      chk("vec_write", o_wr[0], vecs[v].exp_wr);
      chk("vec_addr", o_addr[0], vecs[v].addr);
      chk("vec_wdata", o_wd[0], vecs[v].wd);
      chk("vec_conflict", o_conf[0], vecs[v].exp_conf);
      c_addr[0][vecs[v].client*A +: A] = ~vecs[v].addr;
      step(0);
      chk("vec_addr_held", o_addr[0], vecs[v].addr);
      chk("vec_no_early_fin", o_fin[0], '0);
      s_fin[0] = 1'b1;
      s_rdata[0] = vecs[v].rdata;
      #1;
      chk("vec_finished", o_fin[0], vecs[v].exp_fin);
      chk("vec_readdata", o_rdata[0], vecs[v].rdata);
      step(0);
      chk("vec_read_cleared", o_rd[0], 1'b0);
      chk("vec_write_cleared", o_wr[0], 1'b0);
      chk("vec_idle", o_busy[0], 1'b0);
      s_fin[0] = 1'b0;
      c_rd[0] = '0;
      c_wr[0] = '0;
      c_addr[0] = '0;
      c_wd[0] = '0;
      step(0);
    end

    // Stray finished in IDLE.
    s_fin[0] = 1'b1;
    #1;
    chk("stray_fin", o_fin[0], '0);
    step(0);
    chk("stray_idle", o_busy[0], 1'b0);
    s_fin[0] = 1'b0;

    // Round-robin among clients 0, 1, 4 requesting continuously.
    do_reset();
    c_rd[0] = 5'b10011;
    c_addr[0] = {23'h000444, 23'h0, 23'h0, 23'h000111, 23'h000100};
    exp_q = '{3'd0, 3'd1, 3'd4, 3'd0, 3'd1, 3'd4};
    for (int j = 0; j < 6; j++) begin
      step(0);
      chk("rr_granted", o_busy[0], 1'b1);
      s_fin[0] = 1'b1;
      step(0);
      s_fin[0] = 1'b0;
      chk("rr_bubble", o_busy[0], 1'b0);
    end
    compare_order("rr_order");

    // Fixed priority: client 0 dominates until it drops, then 1, then 4.
    do_reset();
    c_rd[1] = 5'b10011;
    c_addr[1] = {23'h000444, 23'h0, 23'h0, 23'h000111, 23'h000100};
    exp_q = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd4};
    for (int j = 0; j < 5; j++) begin
      if (j == 3) c_rd[1][0] = 1'b0;
      if (j == 4) c_rd[1][1] = 1'b0;
      step(1);
      chk("fx_granted", o_busy[1], 1'b1);
      s_fin[1] = 1'b1;
      step(1);
      s_fin[1] = 1'b0;
    end
    compare_order("fx_order");

    // Reset mid-BUSY abandons the grant and returns rr_ptr to 0.
    do_reset();
    c_rd[0][2] = 1'b1;
    step(0);
    chk("mid_grant", o_gid[0], 3'd2);
    step(0);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    chk("mid_rst_busy", o_busy[0], 1'b0);
    chk("mid_rst_read", o_rd[0], 1'b0);
    chk("mid_rst_grant", o_gid[0], '0);
    c_rd[0] = 5'b10010;
    step(0);
    chk("mid_rst_ptr_zero", o_gid[0], 3'd1);
    s_fin[0] = 1'b1;
    step(0);
    s_fin[0] = 1'b0;
    c_rd[0] = '0;
    step(0);

    // Randomized traffic per arbitration mode.
    do_reset();
    random_phase(0, 600);
    do_reset();
    random_phase(1, 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
